// File: rtl/cpu_types_pkg.sv
// Shared types for the EX-stage multiply/divide unit: operation codes, FSM states, iteration count.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      MD_MULTU = 2'd0,
      MD_MULT  = 2'd1,
      MD_DIVU  = 2'd2,
      MD_DIV   = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

   localparam int MULDIV_ITERS = 32;

   function automatic logic op_is_div(input muldiv_op_t op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input muldiv_op_t op);
      return op[0];
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] opnd,
   input  logic               mq_bit,
   output logic [2*WIDTH-1:0] acc_nxt,
   output logic               qbit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      acc_nxt = acc;
      qbit    = 1'b0;
      shifted = {acc[WIDTH-1:0], mq_bit};
      diff    = {1'b0, shifted} - {2'b00, opnd[WIDTH-1:0]};
      if (is_div) begin
         // diff[WIDTH+1] is the borrow: trial subtraction failed, keep the shifted remainder
         if (!diff[WIDTH+1]) begin
            acc_nxt = {{(WIDTH-1){1'b0}}, diff[WIDTH:0]};
            qbit    = 1'b1;
         end else begin
            acc_nxt = {{(WIDTH-1){1'b0}}, shifted};
         end
      end else if (mq_bit) begin
         acc_nxt = acc + opnd;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO; busy stalls the front end while running.
// Build option: MULDIV_EARLY_TERM_EN lets multiplies leave CALC once the multiplier is exhausted.
//
//  state | meaning
//  IDLE  | waiting for start; mthi/mtlo writes accepted
//  CALC  | one multiply/divide bit per cycle
//  FIX   | sign correction, HI/LO written on exit
module ex_muldiv_unit
   import cpu_types_pkg::*;
#(
   parameter int WIDTH = MULDIV_ITERS,
   parameter int ITERS = WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             flush,
   input  logic             hilo_wen,
   input  logic             hilo_sel,
   input  logic [WIDTH-1:0] hilo_wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(ITERS);

   muldiv_state_t      state;
   logic [CW-1:0]      cnt;
   logic               is_div, neg_res, neg_rem, div0, done_q;
   logic [2*WIDTH-1:0] acc, opnd, acc_nxt, prod;
   logic [WIDTH-1:0]   mq, hi_q, lo_q, abs_a, abs_b, quo, rem;
   logic               sgn, mq_bit, qbit, last_iter;

   assign sgn   = op_is_signed(muldiv_op_t'(op));
   assign abs_a = (sgn && opa[WIDTH-1]) ? -opa : opa;
   assign abs_b = (sgn && opb[WIDTH-1]) ? -opb : opb;

   // Multiply consumes the multiplier LSB-first; divide feeds dividend bits MSB-first.
   assign mq_bit = is_div ? mq[WIDTH-1] : mq[0];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc     (acc),
      .opnd    (opnd),
      .mq_bit  (mq_bit),
      .acc_nxt (acc_nxt),
      .qbit    (qbit)
   );

`ifdef MULDIV_EARLY_TERM_EN
   assign last_iter = (cnt == CW'(ITERS-1)) || (!is_div && ((mq >> 1) == '0));
`else
   assign last_iter = (cnt == CW'(ITERS-1));
`endif

   always_comb begin
      prod = neg_res ? -acc : acc;
      quo  = div0 ? '1 : (neg_res ? -mq : mq);
      rem  = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   assign busy = (state != IDLE) || (start && !flush);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
         acc     <= '0;
         opnd    <= '0;
         mq      <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (hilo_wen) begin
                     if (hilo_sel) hi_q <= hilo_wdata;
                     else          lo_q <= hilo_wdata;
                  end
                  if (start) begin
                     state   <= CALC;
                     cnt     <= '0;
                     is_div  <= op[1];
                     neg_res <= sgn && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                     neg_rem <= sgn && opa[WIDTH-1];
                     div0    <= (opb == '0);
                     acc     <= '0;
                     opnd    <= {{WIDTH{1'b0}}, (op[1] ? abs_b : abs_a)};
                     mq      <= op[1] ? abs_a : abs_b;
                  end
               end
               CALC: begin
                  acc  <= acc_nxt;
                  cnt  <= cnt + 1'b1;
                  mq   <= is_div ? {mq[WIDTH-2:0], qbit} : (mq >> 1);
                  opnd <= is_div ? opnd : (opnd << 1);
                  if (last_iter) state <= FIX;
               end
               FIX: begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                  if (is_div) begin
                     hi_q <= rem;
                     lo_q <= quo;
                  end else begin
                     hi_q <= prod[2*WIDTH-1:WIDTH];
                     lo_q <= prod[WIDTH-1:0];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, random ops vs. arithmetic model, flush/reset sequences.
module tb_ex_muldiv_unit;

   logic        CLK = 1'b0;
   logic        RST, start, flush, hilo_wen, hilo_sel;
   logic [1:0]  op;
   logic [31:0] opa, opb, hilo_wdata, hi, lo;
   logic        busy, done;

   int checks = 0;
   int errors = 0;

   ex_muldiv_unit dut (
      .CLK(CLK), .RST(RST), .start(start), .op(op), .opa(opa), .opb(opb),
      .flush(flush), .hilo_wen(hilo_wen), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural rules.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q, r;
      logic [31:0] uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'd0: return {32'b0, a} * {32'b0, b};
         2'd1: begin p = sa * sb; return p; end
         2'd2: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            uq = a / b; ur = a % b;
            return {ur, uq};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            q = sa / sb; r = sa % sb;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Cycle in which done is expected, counting the start cycle as 0.
   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
      int n;
      logic [31:0] ab;
      n  = 32;
      ab = (o[0] && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_TERM_EN
      if (!o[1]) begin
         n = 1;
         for (int i = 0; i < 32; i++) if (ab[i]) n = i + 1;
      end
`endif
      return n + 2;
   endfunction

   task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
      int lat, k;
      logic got, busy_ok;
      lat = exp_lat(o, b);
      got = 1'b0;
      busy_ok = 1'b1;
      k = 0;
      @(negedge CLK);
      start = 1'b1; op = o; opa = a; opb = b;
      #1 chk({nm, "_busy_c0"}, busy, 1'b1);
      while (!got && k < lat + 5) begin
         @(negedge CLK);
         k++;
         start = 1'b0; opa = $urandom; opb = $urandom;
         #1;
         if (done) got = 1'b1;
         else if (!busy) busy_ok = 1'b0;
      end
      chk({nm, "_latency"}, got ? k : -1, lat);
      chk({nm, "_hi"}, hi, ehi);
      chk({nm, "_lo"}, lo, elo);
      chk({nm, "_busy_held"}, busy_ok, 1'b1);
      chk({nm, "_busy_at_done"}, busy, 1'b0);
      @(negedge CLK);
      #1 chk({nm, "_done_1cyc"}, done, 1'b0);
   endtask

   task automatic quiet(input string nm, input int n);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         #1 if (done || busy) seen = 1'b1;
      end
      chk({nm, "_quiet"}, seen, 1'b0);
   endtask

   vec_t vecs[10];
   logic [63:0] m;
   logic [1:0]  ro;
   logic [31:0] ra, rb, hold_hi, hold_lo;
   logic        done_seen, busy_ok;
   int          lat;

   initial begin
      RST = 1'b1; start = 1'b0; flush = 1'b0; hilo_wen = 1'b0; hilo_sel = 1'b0;
      op = 2'd0; opa = '0; opb = '0; hilo_wdata = '0;

      vecs[0] = '{2'd0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[1] = '{2'd1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2] = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{2'd2, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
      vecs[4] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5] = '{2'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[6] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7] = '{2'd2, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
      vecs[8] = '{2'd0, 32'd5,        32'd3,        32'h00000000, 32'd15};
      vecs[9] = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

      repeat (2) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom_range(0, 15);
            1:       rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         m = model(ro, ra, rb);
         run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, m[63:32], m[31:0]);
      end

      // mthi/mtlo in IDLE
      @(negedge CLK); hilo_wen = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hCAFE0001;
      @(negedge CLK); hilo_sel = 1'b0; hilo_wdata = 32'h0BAD0002;
      @(negedge CLK); hilo_wen = 1'b0;
      #1;
      chk("mthi", hi, 32'hCAFE0001);
      chk("mtlo", lo, 32'h0BAD0002);

      // DIVU flushed at cycle 10; mthi during CALC ignored; restart at cycle 12
      @(negedge CLK); start = 1'b1; op = 2'd2; opa = 32'd1000; opb = 32'd7;
      done_seen = 1'b0; busy_ok = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge CLK);
         start = 1'b0; flush = (c == 10); hilo_wen = (c == 5); hilo_sel = 1'b1; hilo_wdata = 32'hFFFFFFFF;
         #1;
         if (done) done_seen = 1'b1;
         if (c <= 10 && !busy) busy_ok = 1'b0;
      end
      chk("flush_busy_before", busy_ok, 1'b1);
      chk("flush_busy_after", busy, 1'b0);
      chk("flush_hi_kept", hi, 32'hCAFE0001);
      chk("flush_lo_kept", lo, 32'h0BAD0002);
      chk("flush_no_done", done_seen, 1'b0);
      run_op("after_flush", 2'd2, 32'd1000, 32'd7, 32'd6, 32'd142);

      // flush beats a simultaneous start
      @(negedge CLK); start = 1'b1; flush = 1'b1; op = 2'd0; opa = 32'd9; opb = 32'd9;
      #1 chk("flush_start_busy", busy, 1'b0);
      @(negedge CLK); start = 1'b0; flush = 1'b0;
      quiet("flush_start", 40);
      chk("flush_start_lo", lo, 32'd142);

      // start held high through the whole operation starts only one
      lat = exp_lat(2'd0, 32'h2);
      @(negedge CLK); start = 1'b1; op = 2'd0; opa = 32'hFFFFFFFF; opb = 32'h2;
      done_seen = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         @(negedge CLK);
         start = (c < lat); opa = $urandom; opb = $urandom;
         #1 if (done) done_seen = 1'b1;
      end
      chk("held_done", done, 1'b1);
      chk("held_hi", hi, 32'h00000001);
      chk("held_lo", lo, 32'hFFFFFFFE);
      chk("held_early_done", done_seen && (lat > 0), 1'b1);
      @(negedge CLK); #1 chk("held_done_pulse", done, 1'b0);
      quiet("held", 40);

      // RST in cycle 20 of a long MULT
      @(negedge CLK); start = 1'b1; op = 2'd1; opa = 32'd12345; opb = 32'h80000001;
      for (int c = 1; c <= 21; c++) begin
         @(negedge CLK);
         start = 1'b0; RST = (c == 20);
      end
      #1;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      quiet("rst", 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
